// File: rtl/uart_led_cmd_pkg.sv
// Shared definitions for the UART LED command parser: ASCII constants,
// FSM state encodings, the response payload and ASCII<->nibble helpers.
package uart_led_cmd_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned NIB_W  = 4;

  localparam logic [BYTE_W-1:0] ASC_R  = 8'h52;
  localparam logic [BYTE_W-1:0] ASC_G  = 8'h47;
  localparam logic [BYTE_W-1:0] ASC_B  = 8'h42;
  localparam logic [BYTE_W-1:0] ASC_Q  = 8'h51;
  localparam logic [BYTE_W-1:0] ASC_K  = 8'h4B;
  localparam logic [BYTE_W-1:0] ASC_E  = 8'h45;
  localparam logic [BYTE_W-1:0] ASC_CR = 8'h0D;
  localparam logic [BYTE_W-1:0] ASC_LF = 8'h0A;

  // Command parser states
  typedef enum logic [2:0] {
    PS_IDLE,
    PS_GET_H,
    PS_GET_L,
    PS_GET_CR,
    PS_Q_CH,
    PS_Q_CR,
    PS_RESP
  } parse_state_e;

  // Response sender states
  typedef enum logic [1:0] {
    SS_IDLE,
    SS_WAIT_HI,
    SS_WAIT_LO
  } send_state_e;

  typedef enum logic [1:0] {
    CH_R,
    CH_G,
    CH_B
  } chan_e;

  // Up-to-two-byte response handed from parser to sender
  typedef struct packed {
    logic              two;
    logic [BYTE_W-1:0] byte1;
    logic [BYTE_W-1:0] byte0;
  } resp_t;

  function automatic logic is_hex(input logic [BYTE_W-1:0] c);
    return ((c >= 8'h30) && (c <= 8'h39)) ||
           ((c >= 8'h41) && (c <= 8'h46)) ||
           ((c >= 8'h61) && (c <= 8'h66));
  endfunction

  // Only meaningful when is_hex(c) holds
  function automatic logic [NIB_W-1:0] hex2nib(input logic [BYTE_W-1:0] c);
    logic [NIB_W-1:0] n;
    if (c <= 8'h39)      n = NIB_W'(c - 8'h30);
    else if (c <= 8'h46) n = NIB_W'(c - 8'h37);
    else                 n = NIB_W'(c - 8'h57);
    return n;
  endfunction

  // Uppercase ASCII hex digit
  function automatic logic [BYTE_W-1:0] nib2hex(input logic [NIB_W-1:0] n);
    return (n < 4'd10) ? (8'h30 + BYTE_W'(n)) : (8'h37 + BYTE_W'(n));
  endfunction

  function automatic logic is_chan(input logic [BYTE_W-1:0] c);
    return (c == ASC_R) || (c == ASC_G) || (c == ASC_B);
  endfunction

  function automatic chan_e chan_of(input logic [BYTE_W-1:0] c);
    chan_e ch;
    unique case (c)
      ASC_G:   ch = CH_G;
      ASC_B:   ch = CH_B;
      default: ch = CH_R;
    endcase
    return ch;
  endfunction

  function automatic resp_t resp_one(input logic [BYTE_W-1:0] b);
    resp_t r;
    r.two   = 1'b0;
    r.byte1 = '0;
    r.byte0 = b;
    return r;
  endfunction

  function automatic resp_t resp_two(input logic [BYTE_W-1:0] b0,
                                     input logic [BYTE_W-1:0] b1);
    resp_t r;
    r.two   = 1'b1;
    r.byte1 = b1;
    r.byte0 = b0;
    return r;
  endfunction

endpackage

// File: rtl/uart_led_cmd_resp_sender.sv
// Response sender: buffers a 1- or 2-byte response and paces it into the
// UART transmitter with a start / busy-high / busy-low handshake per byte.
// Ports:
//   CLK, RST_N  clock, async active-low reset
//   load        one-cycle request carrying resp (accepted only when idle)
//   resp        response payload
//   tx_busy     transmitter busy flag
//   tx_start    one-cycle start pulse (registered)
//   tx_data     byte being transmitted (registered, held until next start)
//   done_c      last byte's busy fell this cycle
module uart_led_cmd_resp_sender
  import uart_led_cmd_pkg::*;
(
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              load,
  input  resp_t             resp,
  input  logic              tx_busy,
  output logic              tx_start,
  output logic [BYTE_W-1:0] tx_data,
  output logic              done_c
);

  send_state_e       state_q, state_d;
  logic              tx_start_d;
  logic [BYTE_W-1:0] tx_data_d;
  logic [BYTE_W-1:0] pend_q, pend_d;
  logic              more_q, more_d;

  // State and registered outputs
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= SS_IDLE;
      tx_start <= 1'b0;
      tx_data  <= '0;
      pend_q   <= '0;
      more_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      tx_start <= tx_start_d;
      tx_data  <= tx_data_d;
      pend_q   <= pend_d;
      more_q   <= more_d;
    end
  end

  // Handshake sequencing
  always_comb begin
    state_d    = state_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data;
    pend_d     = pend_q;
    more_d     = more_q;
    done_c     = 1'b0;
    unique case (state_q)
      SS_IDLE: begin
        if (load) begin
          tx_start_d = 1'b1;
          tx_data_d  = resp.byte0;
          pend_d     = resp.byte1;
          more_d     = resp.two;
          state_d    = SS_WAIT_HI;
        end
      end
      SS_WAIT_HI: begin
        if (tx_busy) state_d = SS_WAIT_LO;
      end
      SS_WAIT_LO: begin
        if (!tx_busy) begin
          if (more_q) begin
            tx_start_d = 1'b1;
            tx_data_d  = pend_q;
            more_d     = 1'b0;
            state_d    = SS_WAIT_HI;
          end else begin
            done_c  = 1'b1;
            state_d = SS_IDLE;
          end
        end
      end
      default: state_d = SS_IDLE;
    endcase
  end

endmodule

// File: rtl/uart_led_cmd.sv
// UART LED command parser. Accepts "<ch><hexH><hexL>CR" to set an RGB PWM
// step and "Q<ch>CR" to read one back; answers 'K', 'E' or two hex digits.
// Ports:
//   CLK, RST_N                  clock, async active-low reset
//   rx_data_i, rx_valid_i       received byte and its one-cycle strobe
//   tx_data_o, tx_start_o       response byte and start pulse
//   tx_busy_i                   transmitter busy
//   red/green/blue_step_o       PWM duty registers
module uart_led_cmd
  import uart_led_cmd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 2500000
)
(
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [BYTE_W-1:0] rx_data_i,
  input  logic              rx_valid_i,
  output logic [BYTE_W-1:0] tx_data_o,
  output logic              tx_start_o,
  input  logic              tx_busy_i,
  output logic [BYTE_W-1:0] red_step_o,
  output logic [BYTE_W-1:0] green_step_o,
  output logic [BYTE_W-1:0] blue_step_o
);

  localparam int unsigned TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  parse_state_e      state_q, state_d;
  chan_e             chan_q, chan_d;
  logic [NIB_W-1:0]  nib_h_q, nib_h_d;
  logic [NIB_W-1:0]  nib_l_q, nib_l_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [BYTE_W-1:0] red_d, green_d, blue_d;
  logic [BYTE_W-1:0] sel_step_c;
  logic              in_cmd_c;
  logic              tmo_hit_c;
  logic              load_c;
  resp_t             resp_c;
  logic              done_c;

  // State, latches, timeout counter and step registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= PS_IDLE;
      chan_q       <= CH_R;
      nib_h_q      <= '0;
      nib_l_q      <= '0;
      tmo_q        <= '0;
      red_step_o   <= '0;
      green_step_o <= '0;
      blue_step_o  <= '0;
    end else begin
      state_q      <= state_d;
      chan_q       <= chan_d;
      nib_h_q      <= nib_h_d;
      nib_l_q      <= nib_l_d;
      tmo_q        <= tmo_d;
      red_step_o   <= red_d;
      green_step_o <= green_d;
      blue_step_o  <= blue_d;
    end
  end

  // Step value of the latched channel, for queries
  always_comb begin
    sel_step_c = red_step_o;
    unique case (chan_q)
      CH_G:    sel_step_c = green_step_o;
      CH_B:    sel_step_c = blue_step_o;
      default: sel_step_c = red_step_o;
    endcase
  end

  assign in_cmd_c  = state_q inside {PS_GET_H, PS_GET_L, PS_GET_CR, PS_Q_CH, PS_Q_CR};
  assign tmo_hit_c = (tmo_q == TMO_W'(TIMEOUT_CYC - 1));

  // Parser next state; any unexpected byte inside a command answers 'E'
  always_comb begin
    state_d = state_q;
    chan_d  = chan_q;
    nib_h_d = nib_h_q;
    nib_l_d = nib_l_q;
    tmo_d   = '0;
    red_d   = red_step_o;
    green_d = green_step_o;
    blue_d  = blue_step_o;
    load_c  = 1'b0;
    resp_c  = resp_one(ASC_E);

    // Counts idle cycles inside a command; a byte always restarts it
    if (in_cmd_c && !rx_valid_i && !tmo_hit_c) tmo_d = tmo_q + TMO_W'(1);

    unique case (state_q)
      PS_IDLE: begin
        if (rx_valid_i) begin
          if (is_chan(rx_data_i)) begin
            chan_d  = chan_of(rx_data_i);
            state_d = PS_GET_H;
          end else if (rx_data_i == ASC_Q) begin
            state_d = PS_Q_CH;
          end else if ((rx_data_i != ASC_CR) && (rx_data_i != ASC_LF)) begin
            load_c  = 1'b1;
            state_d = PS_RESP;
          end
        end
      end
      PS_GET_H: begin
        if (rx_valid_i) begin
          if (is_hex(rx_data_i)) begin
            nib_h_d = hex2nib(rx_data_i);
            state_d = PS_GET_L;
          end else begin
            load_c  = 1'b1;
            state_d = PS_RESP;
          end
        end
      end
      PS_GET_L: begin
        if (rx_valid_i) begin
          if (is_hex(rx_data_i)) begin
            nib_l_d = hex2nib(rx_data_i);
            state_d = PS_GET_CR;
          end else begin
            load_c  = 1'b1;
            state_d = PS_RESP;
          end
        end
      end
      PS_GET_CR: begin
        if (rx_valid_i) begin
          load_c  = 1'b1;
          state_d = PS_RESP;
          if (rx_data_i == ASC_CR) begin
            resp_c = resp_one(ASC_K);
            unique case (chan_q)
              CH_G:    green_d = {nib_h_q, nib_l_q};
              CH_B:    blue_d  = {nib_h_q, nib_l_q};
              default: red_d   = {nib_h_q, nib_l_q};
            endcase
          end
        end
      end
      PS_Q_CH: begin
        if (rx_valid_i) begin
          if (is_chan(rx_data_i)) begin
            chan_d  = chan_of(rx_data_i);
            state_d = PS_Q_CR;
          end else begin
            load_c  = 1'b1;
            state_d = PS_RESP;
          end
        end
      end
      PS_Q_CR: begin
        if (rx_valid_i) begin
          load_c  = 1'b1;
          state_d = PS_RESP;
          if (rx_data_i == ASC_CR) begin
            resp_c = resp_two(nib2hex(sel_step_c[7:4]), nib2hex(sel_step_c[3:0]));
          end
        end
      end
      PS_RESP: begin
        // Incoming bytes are dropped until the sender finishes
        if (done_c) state_d = PS_IDLE;
      end
      default: state_d = PS_IDLE;
    endcase

    // A byte landing on the expiry cycle wins over the timeout
    if (in_cmd_c && !rx_valid_i && tmo_hit_c) state_d = PS_IDLE;
  end

  uart_led_cmd_resp_sender u_resp_sender (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .load     (load_c),
    .resp     (resp_c),
    .tx_busy  (tx_busy_i),
    .tx_start (tx_start_o),
    .tx_data  (tx_data_o),
    .done_c   (done_c)
  );

endmodule

// File: tb/tb_uart_led_cmd.sv
// Bench for uart_led_cmd: directed scenarios plus random command streams,
// checked against a string-level model of the command grammar and a
// transmitter emulation that enforces the start/busy handshake.
module tb_uart_led_cmd;

  localparam int unsigned TMO = 100;

  logic       CLK;
  logic       RST_N;
  logic [7:0] rx_data_i;
  logic       rx_valid_i;
  logic [7:0] tx_data_o;
  logic       tx_start_o;
  logic       tx_busy_i;
  logic [7:0] red_step_o;
  logic [7:0] green_step_o;
  logic [7:0] blue_step_o;

  uart_led_cmd #(.TIMEOUT_CYC(TMO)) dut (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .rx_data_i    (rx_data_i),
    .rx_valid_i   (rx_valid_i),
    .tx_data_o    (tx_data_o),
    .tx_start_o   (tx_start_o),
    .tx_busy_i    (tx_busy_i),
    .red_step_o   (red_step_o),
    .green_step_o (green_step_o),
    .blue_step_o  (blue_step_o)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- transmitter emulation ----------------
  logic [7:0] tx_log[$];
  bit         xmit_active;
  logic [7:0] frame_byte;
  int         d_rise;
  int         f_len;

  initial begin
    tx_busy_i   = 1'b0;
    xmit_active = 1'b0;
    forever begin
      @(negedge CLK);
      if (tx_start_o == 1'b1) begin
        frame_byte  = tx_data_o;
        tx_log.push_back(frame_byte);
        xmit_active = 1'b1;
        d_rise      = $urandom_range(1, 2);
        f_len       = $urandom_range(3, 6);
        repeat (d_rise) begin
          @(negedge CLK);
          check("start_pulse_width", 32'(tx_start_o), 32'd0);
          check("data_hold", 32'(tx_data_o), 32'(frame_byte));
        end
        tx_busy_i = 1'b1;
        repeat (f_len) begin
          @(negedge CLK);
          check("start_while_busy", 32'(tx_start_o), 32'd0);
          check("data_hold", 32'(tx_data_o), 32'(frame_byte));
        end
        tx_busy_i   = 1'b0;
        xmit_active = 1'b0;
      end
    end
  end

  // ---------------- reference model ----------------
  logic [7:0] cmd_q[$];
  logic [7:0] exp_log[$];
  logic [7:0] m_step[3];
  int         gap;
  bit         m_resp;

  function automatic int chan_idx(input logic [7:0] c);
    if (c == 8'h52) return 0;
    if (c == 8'h47) return 1;
    if (c == 8'h42) return 2;
    return -1;
  endfunction

  function automatic int hex_val(input logic [7:0] c);
    if (c >= 8'h30 && c <= 8'h39) return int'(c) - 48;
    if (c >= 8'h41 && c <= 8'h46) return int'(c) - 65 + 10;
    if (c >= 8'h61 && c <= 8'h66) return int'(c) - 97 + 10;
    return -1;
  endfunction

  function automatic logic [7:0] hex_char(input int n, input bit lower);
    if (n < 10) return 8'(48 + n);
    return lower ? 8'(97 + n - 10) : 8'(65 + n - 10);
  endfunction

  function automatic void respond(input logic [7:0] b);
    exp_log.push_back(b);
  endfunction

  // Feeds one byte to the model; returns number of response bytes produced
  task automatic model_byte(input logic [7:0] b, output int n_resp);
    int sz;
    n_resp = 0;
    if (m_resp) return;
    if (cmd_q.size() != 0 && gap >= int'(TMO)) cmd_q.delete();
    cmd_q.push_back(b);
    sz = cmd_q.size();
    if (chan_idx(cmd_q[0]) >= 0) begin
      if (sz == 2 || sz == 3) begin
        if (hex_val(b) < 0) begin respond(8'h45); n_resp = 1; end
      end else if (sz == 4) begin
        if (b == 8'h0D) begin
          m_step[chan_idx(cmd_q[0])] = 8'(hex_val(cmd_q[1]) * 16 + hex_val(cmd_q[2]));
          respond(8'h4B);
        end else begin
          respond(8'h45);
        end
        n_resp = 1;
      end
    end else if (cmd_q[0] == 8'h51) begin
      if (sz == 2) begin
        if (chan_idx(b) < 0) begin respond(8'h45); n_resp = 1; end
      end else if (sz == 3) begin
        if (b == 8'h0D) begin
          respond(hex_char(int'(m_step[chan_idx(cmd_q[1])]) / 16, 1'b0));
          respond(hex_char(int'(m_step[chan_idx(cmd_q[1])]) % 16, 1'b0));
          n_resp = 2;
        end else begin
          respond(8'h45);
          n_resp = 1;
        end
      end
    end else if (b == 8'h0D || b == 8'h0A) begin
      cmd_q.delete();
    end else begin
      respond(8'h45);
      n_resp = 1;
    end
    if (n_resp > 0) begin
      cmd_q.delete();
      m_resp = 1'b1;
    end
  endtask

  // ---------------- drivers ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
    gap++;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic check_steps();
    check("red_step", 32'(red_step_o), 32'(m_step[0]));
    check("green_step", 32'(green_step_o), 32'(m_step[1]));
    check("blue_step", 32'(blue_step_o), 32'(m_step[2]));
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    rx_data_i  = b;
    rx_valid_i = 1'b1;
    @(posedge CLK);
    #1;
    rx_valid_i = 1'b0;
    rx_data_i  = 8'($urandom);
    model_byte(b, n);
    gap = 0;
    if (n > 0) begin
      check("start_latency", 32'(tx_start_o), 32'd1);
      check("first_byte", 32'(tx_data_o), 32'(exp_log[exp_log.size() - n]));
    end else if (!m_resp) begin
      check("no_start", 32'(tx_start_o), 32'd0);
    end
    check_steps();
  endtask

  task automatic wait_resp();
    int t = 0;
    while ((tx_log.size() < exp_log.size() || xmit_active) && t < 300) begin
      tick();
      t++;
    end
    check("resp_done", 32'(xmit_active), 32'd0);
    idle(2);
    check("resp_count", 32'(tx_log.size()), 32'(exp_log.size()));
    foreach (exp_log[i]) begin
      if (i < tx_log.size()) check("resp_byte", 32'(tx_log[i]), 32'(exp_log[i]));
    end
    tx_log.delete();
    exp_log.delete();
    m_resp = 1'b0;
  endtask

  // junk: bytes pushed at the DUT while it is answering
  task automatic send_seq(input logic [7:0] bq[$], input bit rnd, input int junk);
    foreach (bq[i]) begin
      send_byte(bq[i]);
      if (m_resp) begin
        repeat (junk) send_byte(8'($urandom));
        wait_resp();
      end else if (rnd) begin
        case ($urandom_range(0, 19))
          0:       idle(int'(TMO) - 1);
          1:       idle(int'(TMO) + $urandom_range(0, 3));
          default: idle($urandom_range(0, 3));
        endcase
      end
    end
  endtask

  task automatic send_str(input string s, input int junk);
    logic [7:0] bq[$];
    for (int i = 0; i < s.len(); i++) bq.push_back(s[i]);
    send_seq(bq, 1'b0, junk);
  endtask

  task automatic model_reset();
    cmd_q.delete();
    exp_log.delete();
    tx_log.delete();
    foreach (m_step[i]) m_step[i] = 8'h00;
    m_resp = 1'b0;
    gap    = 0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [7:0] chs[3];
    logic [7:0] bq[$];
    int         v;
    int         ch;
    chs = '{8'h52, 8'h47, 8'h42};
    rx_valid_i = 1'b0;
    rx_data_i  = 8'h00;
    RST_N      = 1'b1;
    model_reset();
    #1 RST_N = 1'b0;
    #2;
    check_steps();
    check("reset_tx_start", 32'(tx_start_o), 32'd0);
    check("reset_tx_data", 32'(tx_data_o), 32'd0);
    repeat (2) @(posedge CLK);
    #1 RST_N = 1'b1;
    tick();

    // Directed scenarios
    send_str("G7F\r", 0);
    send_str("B3c\r", 0);
    send_str("QB\r", 0);
    send_str("RZ", 0);
    send_str("R10\r", 0);
    send_str("R1", 0);
    idle(int'(TMO));
    send_str("\r", 0);
    send_str("R2", 0);
    idle(int'(TMO) - 1);
    send_str("0\r", 0);
    send_str("QR\r", 2);
    send_str("B55\r", 2);
    send_str("\n\rx", 1);

    // Random command stream
    for (int k = 0; k < 80; k++) begin
      bq.delete();
      v  = $urandom_range(0, 255);
      ch = $urandom_range(0, 2);
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4: begin
          bq.push_back(chs[ch]);
          bq.push_back(hex_char(v / 16, 1'($urandom_range(0, 1))));
          bq.push_back(hex_char(v % 16, 1'($urandom_range(0, 1))));
          bq.push_back(8'h0D);
        end
        5, 6: begin
          bq.push_back(8'h51);
          bq.push_back(chs[ch]);
          bq.push_back(8'h0D);
        end
        7: begin
          bq.push_back(chs[ch]);
          bq.push_back(hex_char(v / 16, 1'b0));
          bq.push_back(hex_char(v % 16, 1'b1));
          bq.push_back(8'h0D);
          bq[$urandom_range(0, 3)] = 8'($urandom);
        end
        8: begin
          case ($urandom_range(0, 2))
            0:       bq.push_back(8'h0D);
            1:       bq.push_back(8'h0A);
            default: bq.push_back(8'($urandom));
          endcase
        end
        default: begin
          bq.push_back(8'h51);
          bq.push_back(8'($urandom));
          bq.push_back(8'h0D);
        end
      endcase
      send_seq(bq, 1'b1, $urandom_range(0, 2));
    end

    // Reset in the middle of a set command
    send_str("G7", 0);
    #2 RST_N = 1'b0;
    #1;
    model_reset();
    check_steps();
    repeat (2) @(posedge CLK);
    #1 RST_N = 1'b1;
    idle(20);
    check("post_reset_silence", 32'(tx_log.size()), 32'(exp_log.size()));
    send_str("\r", 0);
    check("post_reset_cr", 32'(tx_log.size()), 32'(exp_log.size()));
    send_str("R10\r", 0);
    send_str("QR\r", 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
